// File: rtl/mvmpu_postproc.sv
// ============================================================================
// Module   : mvmpu_postproc
// Purpose  : Serialises an MVPE_N-lane partial-sum word through bias add,
//            rounded rescale, saturation and ReLU into vector RAM writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvmpu_postproc #(
   parameter int MVPE_N   = 8,
   parameter int INTWIDTH = 16,
   parameter int VAW      = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         din_valid,
   input  logic [MVPE_N*INTWIDTH-1:0]   din,
   output logic                         busy,
   input  logic [7:0]                   cfg_nlanes,
   input  logic [4:0]                   cfg_shift,
   input  logic                         cfg_bias_en,
   input  logic                         cfg_relu,
   input  logic [VAW-1:0]               base_addr,
   output logic                         bias_rd_en,
   output logic [VAW-1:0]               bias_addr,
   input  logic [INTWIDTH-1:0]          bias_din,
   output logic                         wr_en,
   output logic [VAW-1:0]               wr_addr,
   output logic [INTWIDTH-1:0]          wr_data,
   output logic                         done,
   output logic                         overrun
);

   localparam int IDXW = (MVPE_N > 1) ? $clog2(MVPE_N) : 1;
   localparam logic [7:0] c_NMAX  = 8'(MVPE_N);
   localparam logic [5:0] c_SHMAX = 6'(INTWIDTH - 1);
   localparam logic signed [INTWIDTH+1:0] c_SAT_MAX = {3'b000, {(INTWIDTH-1){1'b1}}};
   localparam logic signed [INTWIDTH+1:0] c_SAT_MIN = {3'b111, {(INTWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      FLUSH1 = 2'd2,
      FLUSH2 = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic signed [INTWIDTH-1:0] r_lane [MVPE_N];
   logic [7:0]          r_nlanes;
   logic [4:0]          r_shift;
   logic                r_bias_en;
   logic                r_relu;
   logic [VAW-1:0]      r_base;
   logic [7:0]          r_idx;
   logic                r_s1_valid;
   logic                r_s1_last;
   logic [IDXW-1:0]     r_s1_idx;
   logic                r_wr_en;
   logic [VAW-1:0]      r_wr_addr;
   logic [INTWIDTH-1:0] r_wr_data;
   logic                r_done;
   logic                r_overrun;

   logic                w_accept;
   logic                w_last;
   logic [7:0]          w_nlanes;
   logic [4:0]          w_shift;

   assign w_accept = (r_state == IDLE) && din_valid;
   assign w_last   = (r_idx == (r_nlanes - 8'd1));
   assign w_nlanes = ((cfg_nlanes == 8'd0) || (cfg_nlanes > c_NMAX)) ? c_NMAX : cfg_nlanes;
   assign w_shift  = ({1'b0, cfg_shift} > c_SHMAX) ? c_SHMAX[4:0] : cfg_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (din_valid) w_state_nxt = ISSUE;
         ISSUE:   if (w_last)    w_state_nxt = FLUSH1;
         FLUSH1:  w_state_nxt = FLUSH2;
         FLUSH2:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Job capture and lane issue counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MVPE_N; i++) r_lane[i] <= '0;
         r_nlanes  <= '0;
         r_shift   <= '0;
         r_bias_en <= 1'b0;
         r_relu    <= 1'b0;
         r_base    <= '0;
         r_idx     <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_accept) begin
            for (int i = 0; i < MVPE_N; i++) r_lane[i] <= din[i*INTWIDTH +: INTWIDTH];
            r_nlanes  <= w_nlanes;
            r_shift   <= w_shift;
            r_bias_en <= cfg_bias_en;
            r_relu    <= cfg_relu;
            r_base    <= base_addr;
            r_idx     <= '0;
         end else if (r_state == ISSUE) begin
            r_idx <= r_idx + 8'd1;
         end
         if (din_valid && (r_state != IDLE)) r_overrun <= 1'b1;
      end
   end

   // Lane arithmetic, evaluated in the cycle bias_din is valid
   logic signed [INTWIDTH-1:0] w_lane;
   logic signed [INTWIDTH-1:0] w_bias;
   logic signed [INTWIDTH+1:0] w_sum;
   logic signed [INTWIDTH+1:0] w_half;
   logic signed [INTWIDTH+1:0] w_rnd;
   logic signed [INTWIDTH+1:0] w_shr;
   logic signed [INTWIDTH+1:0] w_sat;
   logic [INTWIDTH-1:0]        w_res;

   always_comb begin
      w_lane = r_lane[r_s1_idx];
      w_bias = r_bias_en ? $signed(bias_din) : '0;
      w_sum  = {{2{w_lane[INTWIDTH-1]}}, w_lane} + {{2{w_bias[INTWIDTH-1]}}, w_bias};
      w_half = (r_shift == 5'd0) ? '0 : ((INTWIDTH+2)'(1) << (r_shift - 5'd1));
      w_rnd  = w_sum + w_half;
      w_shr  = w_rnd >>> r_shift;
      w_sat  = w_shr;
      if (w_shr > c_SAT_MAX) w_sat = c_SAT_MAX;
      else if (w_shr < c_SAT_MIN) w_sat = c_SAT_MIN;
      w_res = w_sat[INTWIDTH-1:0];
      if (r_relu && w_sat[INTWIDTH+1]) w_res = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_idx   <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_s1_valid <= (r_state == ISSUE);
         r_s1_last  <= (r_state == ISSUE) && w_last;
         r_s1_idx   <= r_idx[IDXW-1:0];
         r_wr_en    <= r_s1_valid;
         r_done     <= r_s1_valid && r_s1_last;
         if (r_s1_valid) begin
            r_wr_addr <= r_base + VAW'(r_s1_idx);
            r_wr_data <= w_res;
         end
      end
   end

   assign busy       = (r_state != IDLE);
   assign bias_rd_en = (r_state == ISSUE) && r_bias_en;
   assign bias_addr  = r_base + VAW'(r_idx);
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign done       = r_done;
   assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_mvmpu_postproc.sv
// ============================================================================
// Module   : tb_mvmpu_postproc
// Purpose  : Self-checking bench for mvmpu_postproc against a lane-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvmpu_postproc;

   localparam int NL = 8;
   localparam int IW = 16;
   localparam int AW = 10;
   localparam int AMOD = 1 << AW;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               din_valid = 1'b0;
   logic [NL*IW-1:0]   din = '0;
   logic               busy;
   logic [7:0]         cfg_nlanes = '0;
   logic [4:0]         cfg_shift = '0;
   logic               cfg_bias_en = 1'b0;
   logic               cfg_relu = 1'b0;
   logic [AW-1:0]      base_addr = '0;
   logic               bias_rd_en;
   logic [AW-1:0]      bias_addr;
   logic [IW-1:0]      bias_din = '0;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [IW-1:0]      wr_data;
   logic               done;
   logic               overrun;

   mvmpu_postproc #(.MVPE_N(NL), .INTWIDTH(IW), .VAW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .busy(busy),
      .cfg_nlanes(cfg_nlanes), .cfg_shift(cfg_shift), .cfg_bias_en(cfg_bias_en),
      .cfg_relu(cfg_relu), .base_addr(base_addr), .bias_rd_en(bias_rd_en),
      .bias_addr(bias_addr), .bias_din(bias_din), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Bias RAM: data only meaningful the cycle after a read strobe
   logic [IW-1:0] bias_mem [AMOD];
   always @(posedge clk) bias_din <= bias_rd_en ? bias_mem[bias_addr] : IW'($urandom);

   int err_cnt = 0;
   int chk_cnt = 0;
   bit exp_ovr = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [IW-1:0] ref_calc(input logic [IW-1:0] lane, input logic [IW-1:0] bias,
                                              input int sh, input bit relu);
      int a, b, s, e;
      logic [31:0] r;
      a = $signed(lane);
      b = $signed(bias);
      s = a + b;
      e = (sh >= IW) ? IW - 1 : sh;
      if (e > 0) s = s + (1 << (e - 1));
      s = s >>> e;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      r = s;
      return r[IW-1:0];
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_bias_rd_en"}, bias_rd_en, 0);
      check({tag, "_bias_addr"}, bias_addr, 0);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_overrun"}, overrun, 0);
   endtask

   // Starts at a negedge with the DUT idle; ends at the negedge of T0+N+3.
   task automatic run_job(input logic [NL*IW-1:0] d, input int nl, input int sh,
                          input bit be, input bit rl, input int base,
                          input int inject, input int rst_at);
      int n;
      bit wexp;
      logic [IW-1:0] bv;
      logic [IW-1:0] exp_data [NL];
      n = (nl == 0 || nl > NL) ? NL : nl;
      for (int i = 0; i < n; i++) begin
         bv = be ? bias_mem[(base + i) % AMOD] : '0;
         exp_data[i] = ref_calc(d[i*IW +: IW], bv, sh, rl);
      end
      din = d; din_valid = 1'b1; cfg_nlanes = nl[7:0]; cfg_shift = sh[4:0];
      cfg_bias_en = be; cfg_relu = rl; base_addr = base[AW-1:0];
      @(posedge clk);
      for (int k = 1; k <= n + 2; k++) begin
         @(negedge clk);
         if (k == rst_at) begin
            din_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check_all_zero("midrst");
            exp_ovr = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (12) begin
               @(negedge clk);
               check("postrst_wr_en", wr_en, 0);
               check("postrst_busy", busy, 0);
               check("postrst_overrun", overrun, 0);
               check("postrst_done", done, 0);
            end
            return;
         end
         check("busy", busy, 1);
         check("bias_rd_en", bias_rd_en, (be && k <= n));
         if (be && k <= n) check("bias_addr", bias_addr, (base + k - 1) % AMOD);
         wexp = (k >= 3 && k <= n + 2);
         check("wr_en", wr_en, wexp);
         if (wexp) begin
            check("wr_addr", wr_addr, (base + k - 3) % AMOD);
            check("wr_data", wr_data, exp_data[k-3]);
         end
         check("done", done, (k == n + 2));
         check("overrun", overrun, exp_ovr);
         if (k == 1) begin
            cfg_nlanes = 8'($urandom); cfg_shift = 5'($urandom);
            cfg_bias_en = 1'($urandom); cfg_relu = 1'($urandom);
            base_addr = AW'($urandom);
         end
         din = {4{32'($urandom)}};
         din_valid = (k == inject);
         if (k == inject) exp_ovr = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      check("end_busy", busy, 0);
      check("end_wr_en", wr_en, 0);
      check("end_done", done, 0);
      check("end_bias_rd_en", bias_rd_en, 0);
      check("end_overrun", overrun, exp_ovr);
   endtask

   logic [NL*IW-1:0] d;

   initial begin
      for (int i = 0; i < AMOD; i++) bias_mem[i] = IW'($urandom);
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain pass-through, lanes 1..8
      for (int i = 0; i < NL; i++) d[i*IW +: IW] = IW'(i + 1);
      run_job(d, 8, 0, 1'b0, 1'b0, 'h010, 0, 0);

      // Bias 100 with rounded shift by 2
      for (int i = 0; i < NL; i++) bias_mem['h100 + i] = 16'd100;
      d = {4{32'($urandom)}};
      d[0 +: IW] = 16'd6; d[IW +: IW] = 16'hFFF9;
      run_job(d, 8, 2, 1'b1, 1'b0, 'h100, 0, 0);

      // Saturation extremes, then with ReLU
      bias_mem['h200] = 16'h7FFF; bias_mem['h201] = 16'hFFFF;
      d = {4{32'($urandom)}};
      d[0 +: IW] = 16'h7FFF; d[IW +: IW] = 16'h8000;
      run_job(d, 2, 0, 1'b1, 1'b0, 'h200, 0, 0);
      run_job(d, 2, 0, 1'b1, 1'b1, 'h200, 0, 0);

      // Address wrap with 3 lanes, then nlanes 0 meaning all lanes
      d = {4{32'($urandom)}};
      run_job(d, 3, 1, 1'b1, 1'b0, 'h3FF, 0, 0);
      run_job(d, 0, 3, 1'b0, 1'b0, 'h3FC, 0, 0);

      // Overrun during a job, then back-to-back acceptance
      d = {4{32'($urandom)}};
      run_job(d, 8, 4, 1'b1, 1'b0, 'h020, 4, 0);
      d = {4{32'($urandom)}};
      run_job(d, 8, 20, 1'b1, 1'b1, 'h040, 0, 0);

      // Reset in the middle of a job clears overrun and kills writes
      d = {4{32'($urandom)}};
      run_job(d, 8, 1, 1'b1, 1'b0, 'h060, 2, 5);

      for (int j = 0; j < 40; j++) begin
         int nl, n, inj;
         d = {4{32'($urandom)}};
         if ($urandom_range(0, 3) == 0) d[0 +: IW] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
         nl = $urandom_range(0, 10);
         n = (nl == 0 || nl > NL) ? NL : nl;
         inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 2) : 0;
         run_job(d, nl, $urandom_range(0, 20), 1'($urandom), 1'($urandom),
                 $urandom_range(0, AMOD - 1), inj, 0);
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
